// File: rtl/interval_timer_pkg.sv
// Shared types and constants for the interval timer controller and its counter core.
// INTERVAL_TIMER_PRESCALER_EN enables the clock-enable prescaler in interval_timer_ctrl.
package interval_timer_pkg;

  localparam int unsigned DEF_W     = 4;
  localparam int unsigned DEF_PRE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } timer_state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  function automatic logic state_is_busy(input timer_state_e s);
    return (s == ST_RUN) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/timer_counter_core.sv
// W-bit up-counter datapath: synchronous clear (dominant), increment enable, and a
// terminal-match flag comparing the current count against the supplied limit.
module timer_counter_core
  import interval_timer_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         match_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign match_o = (count_q == limit_i);

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer controller: start/stop/pause FSM around timer_counter_core with one-shot
// or periodic mode. Define INTERVAL_TIMER_PRESCALER_EN to add the presc input and prescaler.
module interval_timer_ctrl
  import interval_timer_pkg::*;
#(
  parameter int unsigned W = DEF_W
`ifdef INTERVAL_TIMER_PRESCALER_EN
  ,
  parameter int unsigned PRE_W = DEF_PRE_W
`endif
) (
  input  logic             clk,
  input  logic             res,
  input  logic             cfg_we,
  input  logic [W-1:0]     cfg_limit,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
`ifdef INTERVAL_TIMER_PRESCALER_EN
  input  logic [PRE_W-1:0] presc,
`endif
  output logic [W-1:0]     count,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  timer_state_e state_q, state_d;
  logic [W-1:0] limit_q, limit_d;
  logic         periodic_q, periodic_d;
  logic         tick_q, tick_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic en;
  logic active;     // counting is allowed this edge (prescaler advances)
  logic restart;    // start or stop taken: counter and prescaler return to zero
  logic wrap;       // periodic terminal count
  logic ctr_inc;
  logic ctr_match;

`ifdef INTERVAL_TIMER_PRESCALER_EN
  logic [PRE_W-1:0] presc_cnt_q, presc_cnt_d;

  // Down-counter reloaded from presc only when en fires, so presc is sampled once per period.
  assign en = (presc_cnt_q == '0);

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    if (restart) begin
      presc_cnt_d = '0;
    end else if (active) begin
      presc_cnt_d = en ? presc : presc_cnt_q - PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      presc_cnt_q <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
    end
  end
`else
  assign en = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    periodic_d = periodic_q;
    tick_d     = 1'b0;
    active     = 1'b0;
    restart    = 1'b0;
    wrap       = 1'b0;
    ctr_inc    = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      restart = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
            restart = 1'b1;
          end else if (cfg_we) begin
            limit_d    = cfg_limit;
            periodic_d = cfg_periodic;
          end
        end
        ST_DONE: begin
          if (start) begin
            state_d = ST_RUN;
            restart = 1'b1;
          end
        end
        ST_RUN, ST_HOLD: begin
          // Leaving HOLD counts on the same edge, so a pause delays by exactly its length.
          if (pause) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_RUN;
            active  = 1'b1;
            if (en) begin
              if (ctr_match) begin
                tick_d = 1'b1;
                if (periodic_q == MODE_PERIODIC) begin
                  wrap = 1'b1;
                end else begin
                  state_d = ST_DONE;
                end
              end else begin
                ctr_inc = 1'b1;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = state_is_busy(state_d);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q    <= ST_IDLE;
      limit_q    <= '1;
      periodic_q <= MODE_ONESHOT;
      tick_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      periodic_q <= periodic_d;
      tick_q     <= tick_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  timer_counter_core #(
    .W (W)
  ) u_core (
    .clk_i   (clk),
    .rst_ni  (res),
    .clr_i   (restart | wrap),
    .inc_i   (ctr_inc),
    .limit_i (limit_q),
    .count_o (count),
    .match_o (ctr_match)
  );

  assign tick = tick_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed self-checking bench for interval_timer_ctrl; expected values are hand-computed.
// Covers the prescaler case as well when INTERVAL_TIMER_PRESCALER_EN is defined.
module tb_interval_timer_ctrl;
  import interval_timer_pkg::*;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         res;
  logic         cfg_we;
  logic [W-1:0] cfg_limit;
  logic         cfg_periodic;
  logic         start;
  logic         stop;
  logic         pause;
  logic [W-1:0] count;
  logic         busy;
  logic         tick;
  logic         done;
`ifdef INTERVAL_TIMER_PRESCALER_EN
  logic [7:0]   presc;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  interval_timer_ctrl #(
    .W (W)
  ) dut (
    .clk          (clk),
    .res          (res),
    .cfg_we       (cfg_we),
    .cfg_limit    (cfg_limit),
    .cfg_periodic (cfg_periodic),
    .start        (start),
    .stop         (stop),
    .pause        (pause),
`ifdef INTERVAL_TIMER_PRESCALER_EN
    .presc        (presc),
`endif
    .count        (count),
    .busy         (busy),
    .tick         (tick),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input int c, input bit b, input bit t,
                            input bit d);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".busy"},  32'(busy),  32'(b));
    check({tag, ".tick"},  32'(tick),  32'(t));
    check({tag, ".done"},  32'(done),  32'(d));
  endtask

  task automatic configure(input int lim, input bit per);
    cfg_we = 1'b1; cfg_limit = W'(lim); cfg_periodic = per;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    res = 1'b0; cfg_we = 1'b0; cfg_limit = '0; cfg_periodic = 1'b0;
    start = 1'b0; stop = 1'b0; pause = 1'b0;
`ifdef INTERVAL_TIMER_PRESCALER_EN
    presc = 8'd0;
`endif
    #2;
    check_outs("reset", 0, 0, 0, 0);
    cyc();
    cyc();
    res = 1'b1;
    cyc();
    check_outs("idle_after_reset", 0, 0, 0, 0);

    // Periodic, limit 3: count 0,1,2,3,0,... with tick on each wrap.
    configure(3, 1'b1);
    do_start();
    check_outs("per_start", 0, 1, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      check_outs($sformatf("per_%0d", i), i % 4, 1, (i % 4) == 0, 0);
    end
    cyc();
    check("per_pre_reset.count", 32'(count), 32'd1);

    // Asynchronous reset mid-run, observed before any clock edge.
    res = 1'b0;
    #2;
    check_outs("async_reset", 0, 0, 0, 0);
    @(negedge clk);
    res = 1'b1;
    cyc();
    cyc();
    check_outs("post_reset_idle", 0, 0, 0, 0);

    // One-shot, limit 5.
    configure(5, 1'b0);
    do_start();
    check_outs("os_start", 0, 1, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      check_outs($sformatf("os_%0d", i), i, 1, 0, 0);
    end
    cyc();
    check_outs("os_expire", 5, 0, 1, 1);
    cyc();
    check_outs("os_done1", 5, 0, 0, 1);
    cyc();
    check_outs("os_done2", 5, 0, 0, 1);
    do_start();
    check_outs("os_restart", 0, 1, 0, 0);
    cyc();
    check_outs("os_restart1", 1, 1, 0, 0);

    // stop beats start in the same cycle.
    stop = 1'b1; start = 1'b1;
    cyc();
    stop = 1'b0; start = 1'b0;
    check_outs("stop_start", 0, 0, 0, 0);
    cyc();
    check_outs("stop_start_idle", 0, 0, 0, 0);

    // Pause at count 2 for 3 cycles, periodic limit 7.
    configure(7, 1'b1);
    do_start();
    cyc();
    cyc();
    check("pz_pre.count", 32'(count), 32'd2);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_outs($sformatf("pz_hold%0d", i), 2, 1, 0, 0);
    end
    pause = 1'b0;
    for (int i = 3; i <= 7; i++) begin
      cyc();
      check_outs($sformatf("pz_run%0d", i), i, 1, 0, 0);
    end
    cyc();
    check_outs("pz_wrap", 0, 1, 1, 0);

    // stop on the terminal-count cycle drops the tick.
    for (int i = 1; i <= 7; i++) cyc();
    check("stop_match_pre.count", 32'(count), 32'd7);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check_outs("stop_match", 0, 0, 0, 0);

    // cfg_we during RUN is ignored: limit 1 keeps a 2-cycle period.
    configure(1, 1'b1);
    do_start();
    cfg_we = 1'b1; cfg_limit = 4'd6; cfg_periodic = 1'b0;
    cyc();
    cfg_we = 1'b0;
    check_outs("lock_1", 1, 1, 0, 0);
    cyc();
    check_outs("lock_2", 0, 1, 1, 0);
    cyc();
    check_outs("lock_3", 1, 1, 0, 0);
    cyc();
    check_outs("lock_4", 0, 1, 1, 0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;

`ifdef INTERVAL_TIMER_PRESCALER_EN
    // presc 2, limit 1, periodic: a count step every 3 clocks, tick every 6.
    presc = 8'd2;
    configure(1, 1'b1);
    do_start();
    for (int k = 1; k <= 12; k++) begin
      int steps;
      steps = (k - 1) / 3 + 1;
      cyc();
      check_outs($sformatf("presc_%0d", k), steps % 2, 1,
                 ((k - 1) % 3 == 0) && (steps % 2 == 0), 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
